// File: rtl/pwm_cmd_sequencer.sv
// pwm_cmd_sequencer
//   Parses 3-byte SPI command frames (CMD, ARG0, ARG1) into per-channel duty
//   settings for NCH PWM generators. Supports immediate set, timed linear
//   fades, fade-rate programming and channel freeze.
//
//   Commands: 0x01 SET ch,val  0x02 FADE ch,val  0x03 RATE x,val
//             0x04 STOP ch (0xFF = all)  0x05 CLRCNT (frame counter builds only)
//
//   Ports:
//     clk_100mhz   system clock
//     rst_n        asynchronous active-low reset
//     rx_data      received SPI byte, qualified by rx_valid
//     rx_valid     single-cycle byte strobe
//     duty_out     channel n duty at [8n+7:8n], registered
//     busy         1 while any channel is still fading (1-cycle lag)
//     frame_err    one-cycle pulse on malformed or aborted frame
//     frame_count  accepted-frame counter
//
//   Build option: define PWM_CMD_FRAME_CNT_EN to enable frame_count and the
//   CLRCNT command; otherwise frame_count is tied to 0 and 0x05 is unknown.
module pwm_cmd_sequencer #(
  parameter int         NCH        = 4,
  parameter int         PRESCALE   = 1000,
  parameter logic [7:0] RATE_RESET = 8'd9,
  parameter int         TIMEOUT    = 100000
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [NCH*8-1:0] duty_out,
  output logic             busy,
  output logic             frame_err,
  output logic [7:0]       frame_count
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT - 1);

  localparam logic [7:0] CMD_SET  = 8'h01;
  localparam logic [7:0] CMD_FADE = 8'h02;
  localparam logic [7:0] CMD_RATE = 8'h03;
  localparam logic [7:0] CMD_STOP = 8'h04;
`ifdef PWM_CMD_FRAME_CNT_EN
  localparam logic [7:0] CMD_CLRCNT = 8'h05;
`endif

  typedef enum logic [1:0] {S_CMD, S_ARG0, S_ARG1, S_EXEC} state_t;

  state_t           state;
  logic [7:0]       cmd, arg0, arg1;
  logic [GAP_W-1:0] gap_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic [7:0]       rate_cnt, rate_reg;
  logic [7:0]       cur [NCH];
  logic [7:0]       tgt [NCH];

  logic             pre_tick, fade_tick;
  logic             stop_all, chan_cmd, ch_ok, exec, exec_err, exec_ok, any_diff;
  logic [3:0]       ch_idx;
  logic [NCH-1:0]   ch_hit;

  function automatic logic cmd_known(input logic [7:0] c);
`ifdef PWM_CMD_FRAME_CNT_EN
    return (c == CMD_SET) || (c == CMD_FADE) || (c == CMD_RATE) ||
           (c == CMD_STOP) || (c == CMD_CLRCNT);
`else
    return (c == CMD_SET) || (c == CMD_FADE) || (c == CMD_RATE) ||
           (c == CMD_STOP);
`endif
  endfunction

  // One step toward the target, saturating at it (never overshoots or wraps).
  function automatic logic [7:0] step_toward(input logic [7:0] c, input logic [7:0] t);
    if (c < t)      return c + 8'd1;
    else if (c > t) return c - 8'd1;
    else            return c;
  endfunction

  // Stage: command decode for the S_EXEC cycle
  always_comb begin
    ch_idx   = arg0[3:0];
    stop_all = (cmd == CMD_STOP) && (arg0 == 8'hFF);
    chan_cmd = (cmd == CMD_SET) || (cmd == CMD_FADE) || (cmd == CMD_STOP);
    ch_ok    = {28'd0, ch_idx} < NCH;
    exec     = (state == S_EXEC);
    exec_err = exec && chan_cmd && !ch_ok && !stop_all;
    exec_ok  = exec && !exec_err;
    ch_hit   = '0;
    for (int n = 0; n < NCH; n++)
      ch_hit[n] = exec_ok && chan_cmd && (stop_all || (ch_idx == 4'(n)));
  end

  // Stage: byte parser with inter-byte timeout
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CMD;
      cmd       <= '0;
      arg0      <= '0;
      arg1      <= '0;
      gap_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_CMD, S_EXEC: begin
          // S_EXEC also accepts the next CMD byte so back-to-back frames work.
          if (exec_err) frame_err <= 1'b1;
          state <= S_CMD;
          if (rx_valid) begin
            cmd     <= rx_data;
            gap_cnt <= '0;
            if (cmd_known(rx_data)) state <= S_ARG0;
            else                    frame_err <= 1'b1;
          end
        end
        S_ARG0, S_ARG1: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (rx_valid) begin
            gap_cnt <= '0;
            if (state == S_ARG0) begin
              arg0  <= rx_data;
              state <= S_ARG1;
            end else begin
              arg1  <= rx_data;
              state <= S_EXEC;
            end
          end else if (gap_cnt == GAP_MAX) begin
            state     <= S_CMD;
            frame_err <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

  // Stage: fade timebase (prescaler then rate divider)
  assign pre_tick  = (pre_cnt == PRE_MAX);
  assign fade_tick = pre_tick && (rate_cnt == rate_reg);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      rate_cnt <= '0;
      rate_reg <= RATE_RESET;
    end else if (exec_ok && (cmd == CMD_RATE)) begin
      rate_reg <= arg1;
      pre_cnt  <= '0;
      rate_cnt <= '0;
    end else begin
      pre_cnt <= pre_tick ? '0 : pre_cnt + 1'b1;
      if (pre_tick) rate_cnt <= (rate_cnt == rate_reg) ? 8'd0 : rate_cnt + 8'd1;
    end
  end

  // Stage: per-channel current/target registers; a command beats a fade tick
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NCH; n++) begin
        cur[n] <= '0;
        tgt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (ch_hit[n]) begin
          if (cmd == CMD_SET) begin
            cur[n] <= arg1;
            tgt[n] <= arg1;
          end else if (cmd == CMD_FADE) begin
            tgt[n] <= arg1;
          end else begin
            tgt[n] <= cur[n];
          end
        end else if (fade_tick) begin
          cur[n] <= step_toward(cur[n], tgt[n]);
        end
      end
    end
  end

  // Stage: status and outputs
  always_comb begin
    any_diff = 1'b0;
    duty_out = '0;
    for (int n = 0; n < NCH; n++) begin
      duty_out[8*n +: 8] = cur[n];
      if (cur[n] != tgt[n]) any_diff = 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= any_diff;
  end

`ifdef PWM_CMD_FRAME_CNT_EN
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)                       frame_count <= '0;
    else if (exec_ok) begin
      if (cmd == CMD_CLRCNT)          frame_count <= '0;
      else                            frame_count <= frame_count + 8'd1;
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
module tb_pwm_cmd_sequencer;

  localparam int NCH      = 4;
  localparam int PRESCALE = 4;
  localparam int TIMEOUT  = 20;
  localparam int NV       = 11;

  logic            clk_100mhz = 1'b0;
  logic            rst_n      = 1'b0;
  logic [7:0]      rx_data    = '0;
  logic            rx_valid   = 1'b0;
  logic [NCH*8-1:0] duty_out;
  logic            busy, frame_err;
  logic [7:0]      frame_count;

  int checks   = 0;
  int failures = 0;

  pwm_cmd_sequencer #(
    .NCH(NCH), .PRESCALE(PRESCALE), .RATE_RESET(8'd9), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .duty_out   (duty_out),
    .busy       (busy),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    int         nb;
    logic [7:0] b0, b1, b2;
    logic       exp_err;
    logic [31:0] exp_duty;
  } vec_t;

  typedef struct {
    int          id;
    logic        exp_err;
    logic [31:0] exp_duty;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t e;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_100mhz);
    rx_valid = 1'b0;
  endtask

  // Sends a full frame and returns on the negedge after the execute cycle.
  task automatic frame(input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1);
    send_byte(c);
    send_byte(a0);
    send_byte(a1);
    @(negedge clk_100mhz);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk_100mhz);
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    @(negedge clk_100mhz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, last;
    int last_cyc, c1, c2;
    bit done;

    vecs[0]  = '{nb:3, b0:8'h01, b1:8'h02, b2:8'h80, exp_err:1'b0, exp_duty:32'h0080_0000};
    vecs[1]  = '{nb:1, b0:8'h07, b1:8'h00, b2:8'h00, exp_err:1'b1, exp_duty:32'h0080_0000};
    vecs[2]  = '{nb:3, b0:8'h01, b1:8'h01, b2:8'h55, exp_err:1'b0, exp_duty:32'h0080_5500};
    vecs[3]  = '{nb:3, b0:8'h01, b1:8'h09, b2:8'h33, exp_err:1'b1, exp_duty:32'h0080_5500};
    vecs[4]  = '{nb:3, b0:8'h01, b1:8'h00, b2:8'hFF, exp_err:1'b0, exp_duty:32'h0080_55FF};
    vecs[5]  = '{nb:3, b0:8'h04, b1:8'hFF, b2:8'h00, exp_err:1'b0, exp_duty:32'h0080_55FF};
    vecs[6]  = '{nb:3, b0:8'h04, b1:8'h05, b2:8'h00, exp_err:1'b1, exp_duty:32'h0080_55FF};
    vecs[7]  = '{nb:3, b0:8'h03, b1:8'h33, b2:8'h07, exp_err:1'b0, exp_duty:32'h0080_55FF};
    vecs[8]  = '{nb:3, b0:8'h01, b1:8'h03, b2:8'h01, exp_err:1'b0, exp_duty:32'h0180_55FF};
    vecs[9]  = '{nb:1, b0:8'h00, b1:8'h00, b2:8'h00, exp_err:1'b1, exp_duty:32'h0180_55FF};
    vecs[10] = '{nb:1, b0:8'hFF, b1:8'h00, b2:8'h00, exp_err:1'b1, exp_duty:32'h0180_55FF};

    // Reset state
    @(negedge clk_100mhz);
    check("rst_duty", duty_out, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_count", 32'(frame_count), 32'h0);
    rst_n = 1'b1;
    @(negedge clk_100mhz);

    // Table of single frames; expectation queued when driven, popped at output time
    for (int i = 0; i < NV; i++) begin
      sb_q.push_back('{id:i, exp_err:vecs[i].exp_err, exp_duty:vecs[i].exp_duty});
      send_byte(vecs[i].b0);
      if (vecs[i].nb == 3) begin
        check($sformatf("vec%0d_duty_early", i), duty_out, (i == 0) ? 32'h0 : vecs[i-1].exp_duty);
        send_byte(vecs[i].b1);
        send_byte(vecs[i].b2);
        check($sformatf("vec%0d_duty_pre", i), duty_out, (i == 0) ? 32'h0 : vecs[i-1].exp_duty);
        @(negedge clk_100mhz);
      end
      e = sb_q.pop_front();
      check($sformatf("vec%0d_err", e.id), 32'(frame_err), 32'(e.exp_err));
      check($sformatf("vec%0d_duty", e.id), duty_out, e.exp_duty);
      check($sformatf("vec%0d_busy", e.id), 32'(busy), 32'h0);
      @(negedge clk_100mhz);
      check($sformatf("vec%0d_err_clear", e.id), 32'(frame_err), 32'h0);
      if (vecs[i].nb == 3 && !vecs[i].exp_err) exp_cnt++;
`ifdef PWM_CMD_FRAME_CNT_EN
      check($sformatf("vec%0d_count", e.id), 32'(frame_count), 32'(exp_cnt));
`else
      check($sformatf("vec%0d_count", e.id), 32'(frame_count), 32'h0);
`endif
    end

    // Back-to-back frames: next CMD byte lands in the execute cycle
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h22);
    @(negedge clk_100mhz);
    check("b2b_duty", duty_out, 32'h0000_2211);
    check("b2b_err", 32'(frame_err), 32'h0);

    // Timeout aborts a partial frame
    do_reset();
    send_byte(8'h01); send_byte(8'h01);
    repeat (TIMEOUT - 1) @(negedge clk_100mhz);
    check("tmo_err_early", 32'(frame_err), 32'h0);
    @(negedge clk_100mhz);
    check("tmo_err", 32'(frame_err), 32'h1);
    @(negedge clk_100mhz);
    check("tmo_err_clear", 32'(frame_err), 32'h0);
    frame(8'h01, 8'h01, 8'hAA);
    check("tmo_recover_duty", 32'(duty_out[15:8]), 32'hAA);
    check("tmo_recover_err", 32'(frame_err), 32'h0);

    // Byte arriving exactly on the expiry cycle is accepted
    do_reset();
    send_byte(8'h01); send_byte(8'h01);
    repeat (TIMEOUT - 1) @(negedge clk_100mhz);
    send_byte(8'hBB);
    check("expiry_err", 32'(frame_err), 32'h0);
    @(negedge clk_100mhz);
    check("expiry_duty", 32'(duty_out[15:8]), 32'hBB);
    check("expiry_err2", 32'(frame_err), 32'h0);

    // Fade with rate 0: one step every PRESCALE cycles
    do_reset();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h04);
    last = 8'h00; last_cyc = -1; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk_100mhz);
      v = duty_out[7:0];
      if (v != last) begin
        check("fade_step", 32'(v), 32'(last + 8'd1));
        check("fade_busy", 32'(busy), 32'h1);
        if (last_cyc >= 0) check("fade_period", 32'(c - last_cyc), 32'd4);
        last_cyc = c;
        last = v;
        if (v == 8'h04) done = 1'b1;
      end
    end
    check("fade_done", 32'(done), 32'h1);
    @(negedge clk_100mhz);
    check("fade_busy_drop", 32'(busy), 32'h0);
    check("fade_final", 32'(duty_out[7:0]), 32'h04);

    // Default rate after reset: (9+1)*PRESCALE cycles per step
    do_reset();
    frame(8'h02, 8'h02, 8'h02);
    c1 = -1; c2 = -1;
    for (int c = 0; c < 200 && c2 < 0; c++) begin
      @(negedge clk_100mhz);
      if (c1 < 0 && duty_out[23:16] == 8'h01) c1 = c;
      if (duty_out[23:16] == 8'h02) c2 = c;
    end
    check("rate_reset_period", 32'(c2 - c1), 32'd40);

    // STOP freezes a fade in progress
    do_reset();
    frame(8'h03, 8'h00, 8'h05);
    frame(8'h02, 8'h00, 8'h10);
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk_100mhz);
      if (duty_out[7:0] == 8'h03) done = 1'b1;
    end
    check("stop_reach3", 32'(done), 32'h1);
    frame(8'h04, 8'h00, 8'h00);
    @(negedge clk_100mhz);
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_duty", 32'(duty_out[7:0]), 32'h03);
    repeat (60) @(negedge clk_100mhz);
    check("stop_duty_hold", 32'(duty_out[7:0]), 32'h03);

    // Mid-operation reset clears fade state and a partial frame
    do_reset();
    frame(8'h02, 8'h00, 8'h40);
    send_byte(8'h01); send_byte(8'h00);
    check("mid_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_duty", duty_out, 32'h0);
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    @(negedge clk_100mhz);
    frame(8'h01, 8'h00, 8'h44);
    check("mid_recover_duty", 32'(duty_out[7:0]), 32'h44);
    check("mid_recover_err", 32'(frame_err), 32'h0);

    // Frame counter / command 0x05
    do_reset();
`ifdef PWM_CMD_FRAME_CNT_EN
    frame(8'h01, 8'h00, 8'h01);
    frame(8'h01, 8'h01, 8'h02);
    frame(8'h02, 8'h02, 8'h03);
    frame(8'h01, 8'h09, 8'h07);
    check("cnt_bad_err", 32'(frame_err), 32'h1);
    @(negedge clk_100mhz);
    check("cnt_three", 32'(frame_count), 32'd3);
    frame(8'h05, 8'h00, 8'h00);
    check("clrcnt_err", 32'(frame_err), 32'h0);
    check("clrcnt_zero", 32'(frame_count), 32'd0);
`else
    frame(8'h01, 8'h00, 8'h01);
    check("cnt_tied", 32'(frame_count), 32'd0);
    send_byte(8'h05);
    check("cmd05_err", 32'(frame_err), 32'h1);
    frame(8'h01, 8'h01, 8'h66);
    check("cmd05_recover", 32'(duty_out[15:8]), 32'h66);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
